// File: rtl/cache_line_bridge_if.sv
// Beat-wide memory bus between the line bridge (master) and the memory (slave).
// Request channel plus independent write and read beat channels, each valid/ready.
interface cache_line_bridge_if #(
  parameter int ADDR_WIDTH    = 64,
  parameter int DATA_WIDTH    = 64,
  parameter int OFFSET_LENGTH = 5
);
  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic                     mem_req_write;
  logic [ADDR_WIDTH-1:0]    mem_req_addr;
  logic [OFFSET_LENGTH-1:0] mem_req_len;
  logic                     mem_wvalid;
  logic                     mem_wready;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic                     mem_wlast;
  logic                     mem_rvalid;
  logic                     mem_rready;
  logic [DATA_WIDTH-1:0]    mem_rdata;
  logic                     mem_rlast;

  modport master (
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_len,
    output mem_wvalid, mem_wdata, mem_wlast, mem_rready,
    input  mem_req_ready, mem_wready, mem_rvalid, mem_rdata, mem_rlast
  );

  modport slave (
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_len,
    input  mem_wvalid, mem_wdata, mem_wlast, mem_rready,
    output mem_req_ready, mem_wready, mem_rvalid, mem_rdata, mem_rlast
  );
endinterface

// File: rtl/cache_line_bridge.sv
// Line <-> beat bridge: one store or load in flight; store acks after N+1 cycles, fill valid after N+2.
// All outputs decode from registered state only, so memory/cache readies never feed a valid combinationally.
module cache_line_bridge #(
  parameter int ADDR_WIDTH    = 64,
  parameter int DATA_WIDTH    = 64,
  parameter int OFFSET_LENGTH = 5
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      command_valid,
  input  logic                                      command_store,
  input  logic                                      command_rready,
  input  logic [ADDR_WIDTH-1:0]                     command_addr,
  input  logic [DATA_WIDTH*(2**OFFSET_LENGTH)-1:0]  data_to_bus,
  output logic                                      bus_ready,
  output logic                                      bus_valid,
  output logic [DATA_WIDTH*(2**OFFSET_LENGTH)-1:0]  fill_data,
  cache_line_bridge_if.master                       mem,
  output logic                                      protocol_err
);
  localparam int N    = 2**OFFSET_LENGTH;
  localparam int LINE = DATA_WIDTH*N;
  localparam logic [OFFSET_LENGTH-1:0] LAST = '1;
  localparam logic [OFFSET_LENGTH-1:0] ONE  = OFFSET_LENGTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    {{(ADDR_WIDTH-OFFSET_LENGTH){1'b1}}, {OFFSET_LENGTH{1'b0}}};

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_DATA, WR_RESP, RD_ACK, RD_REQ, RD_DATA, RD_HOLD
  } state_t;

  state_t                   state, state_nxt;
  logic [OFFSET_LENGTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [LINE-1:0]          line_q;
  logic                     cnt_last;

  assign cnt_last = (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // One line register serves both directions: write-back source and fill destination.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      addr_q       <= '0;
      line_q       <= '0;
      protocol_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (command_valid) begin
            addr_q <= command_addr & LINE_MASK;
            if (command_store) line_q <= data_to_bus;
          end
        end
        WR_DATA: begin
          if (mem.mem_wready) cnt <= cnt_last ? '0 : cnt + ONE;
        end
        RD_DATA: begin
          if (mem.mem_rvalid) begin
            line_q[cnt*DATA_WIDTH +: DATA_WIDTH] <= mem.mem_rdata;
            cnt <= cnt_last ? '0 : cnt + ONE;
            if (mem.mem_rlast != cnt_last) protocol_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt         = state;
    bus_ready         = 1'b0;
    bus_valid         = 1'b0;
    mem.mem_req_valid = 1'b0;
    mem.mem_req_write = 1'b0;
    mem.mem_wvalid    = 1'b0;
    mem.mem_wdata     = '0;
    mem.mem_wlast     = 1'b0;
    mem.mem_rready    = 1'b0;
    case (state)
      IDLE: begin
        if (command_valid) state_nxt = command_store ? WR_REQ : RD_ACK;
      end
      WR_REQ: begin
        mem.mem_req_valid = 1'b1;
        mem.mem_req_write = 1'b1;
        if (mem.mem_req_ready) state_nxt = WR_DATA;
      end
      WR_DATA: begin
        mem.mem_wvalid = 1'b1;
        mem.mem_wdata  = line_q[cnt*DATA_WIDTH +: DATA_WIDTH];
        mem.mem_wlast  = cnt_last;
        if (mem.mem_wready && cnt_last) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        bus_ready = 1'b1;
        state_nxt = IDLE;
      end
      RD_ACK: begin
        bus_ready = 1'b1;
        state_nxt = RD_REQ;
      end
      RD_REQ: begin
        mem.mem_req_valid = 1'b1;
        if (mem.mem_req_ready) state_nxt = RD_DATA;
      end
      // Completion follows the beat count even if rlast disagrees.
      RD_DATA: begin
        mem.mem_rready = 1'b1;
        if (mem.mem_rvalid && cnt_last) state_nxt = RD_HOLD;
      end
      RD_HOLD: begin
        bus_valid = 1'b1;
        if (command_rready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem.mem_req_addr = addr_q;
  assign mem.mem_req_len  = LAST;
  assign fill_data        = line_q;
endmodule
